alarm_unit: RTL and testbench
=============================

// Module: alarm_unit
// PURPOSE
//  Alarm stage downstream of the BCD time counters (hour_high/low, min_high/low, 1 Hz seconds).
//  Holds a user-set BCD alarm time and edits it via debounced active-low buttons.
//  Compares the alarm time against the running time and drives buzzer/ringing.
//  Alarm digits feed the segment7 mux when the display shows the alarm time.
// PARAMETERS
//  DEBOUNCE_CYCLES  50   clk_in cycles a synchronised button must stay stable before it is accepted
//  RING_SECONDS     60   sec_tick rising edges before RINGING auto-stops
//  SNOOZE_SECONDS   300  sec_tick rising edges spent in SNOOZE before re-ringing
// PORTS
//  clk_in          in   1  system clock (PLL output)
//  reset           in   1  synchronous, active-high; one clock
//  sec_tick        in   1  1 Hz square wave from the seconds divider; only rising edges are used
//  cur_hour_high   in   2  running time, BCD 0-2
//  cur_hour_low    in   4  running time, BCD 0-9
//  cur_min_high    in   4  running time, BCD 0-5
//  cur_min_low     in   4  running time, BCD 0-9
//  btn_hour_n      in   1  raw button, active-low: alarm hour +1
//  btn_min_n       in   1  raw button, active-low: alarm minute +1
//  btn_arm_n       in   1  raw button, active-low: toggle armed / stop alarm
//  btn_snooze_n    in   1  raw button, active-low: snooze
//  alarm_hour_high out  2  alarm time, BCD
//  alarm_hour_low  out  4  alarm time, BCD
//  alarm_min_high  out  4  alarm time, BCD
//  alarm_min_low   out  4  alarm time, BCD
//  alarm_armed     out  1  alarm enabled
//  ringing         out  1  high in RINGING
//  buzzer          out  1  ringing AND beep phase
// BEHAVIOUR
//  Reset: alarm time 00:00, alarm_armed=0, FSM IDLE, ringing=0, buzzer=0, all counters 0, debounced levels=1.
//  Buttons: each goes through a 2-flop synchroniser, then a debounce counter.
//   Debounced level changes after DEBOUNCE_CYCLES consecutive equal samples.
//   A press is a single-cycle pulse on debounced 1->0; releases produce nothing.
//   Press pulse appears DEBOUNCE_CYCLES+2..+4 cycles after the raw edge. Pulses shorter than DEBOUNCE_CYCLES are ignored.
//  Tick: sec_tick is registered; tick_pulse = one cycle on its 0->1 edge.
//  Edit, only in IDLE (ignored in RINGING/SNOOZE):
//   hour press: 09->10, 19->20, 23->00; BCD only, never A-F.
//   min press: 09->10, 59->00; no carry into hours.
//   Hour and minute press in the same cycle: both apply.
//  Match: match = (cur HH:MM == alarm HH:MM), registered each cycle.
//   trigger = match 0->1 while alarm_armed and in IDLE.
//   Stopping inside the matching minute does not re-trigger.
//   Editing the alarm onto the current time while armed does trigger.
//  Arm press in IDLE toggles alarm_armed.
//  FSM IDLE -> RINGING on trigger: ring_cnt=0, beep phase=1.
//  RINGING:
//   each tick_pulse: ring_cnt+1, beep phase toggles.
//   ring_cnt reaches RING_SECONDS: -> IDLE, armed stays 1.
//   arm press: -> IDLE, alarm_armed=0.
//   snooze press: see CONFIGURATION.
//  SNOOZE: buzzer=0, ringing=0.
//   Each tick_pulse: snz_cnt+1; reaching SNOOZE_SECONDS -> RINGING, ring_cnt=0.
//   Arm press -> IDLE, alarm_armed=0.
//  Priority within one cycle: reset > arm press > snooze press > timeout > tick count.
//  Outputs are registered; ringing/buzzer update 1 cycle after the causing event.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined: snooze press in RINGING -> SNOOZE with snz_cnt=0.
//  ALARM_SNOOZE_EN undefined: no SNOOZE state and no snz_cnt logic.
//   Snooze press in RINGING -> IDLE, armed stays 1. btn_snooze_n otherwise unused.
// TESTING (DEBOUNCE_CYCLES=4, RING_SECONDS=3, SNOOZE_SECONDS=5)
//  - Reset, hold btn_hour_n low 2 cycles, then 20 cycles -> alarm stays 00:00; glitch rejected.
//  - 24 hour presses, 61 minute presses -> hour sequence ends 23 then 00; minutes end at 01; no non-BCD value ever seen.
//  - Alarm 07:30, armed, cur steps 07:29->07:30 -> ringing=1 within 2 cycles.
//     buzzer toggles per tick; after 3 ticks ringing=0 and alarm_armed=1.
//  - Ringing; arm press and snooze press in the same cycle -> IDLE, alarm_armed=0.
//     Still 07:30 -> no re-trigger.
//  - ALARM_SNOOZE_EN: snooze while ringing -> ringing=0; after 5 ticks ringing=1.
//     Without the macro -> stays IDLE, armed=1.
//  - Reset asserted mid-RINGING -> next cycle ringing=0, buzzer=0, armed=0, alarm 00:00.

Source files
------------

// File: rtl/alarm_unit.sv
// alarm_unit -- alarm stage sitting behind the BCD time counters.
//
// Holds a user-editable BCD alarm time (HH:MM) and edits it with debounced
// active-low buttons. Compares it against the running time and drives
// ringing/buzzer through an IDLE / RINGING (/ SNOOZE) state machine.
//
// Ports:
//   clk_in, reset             system clock, synchronous active-high reset
//   sec_tick                  1 Hz square wave, rising edges counted
//   cur_hour_high..min_low    running time, BCD
//   btn_hour_n/min_n/arm_n/snooze_n  raw active-low buttons
//   alarm_hour_high..min_low  alarm time, BCD (to segment mux)
//   alarm_armed, ringing, buzzer
//
// Build option: define ALARM_SNOOZE_EN to get the SNOOZE state. Without it a
// snooze press while ringing just stops the alarm and leaves it armed.

module alarm_unit #(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int RING_SECONDS    = 60,
    parameter int SNOOZE_SECONDS  = 300
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [1:0] cur_hour_high,
    input  logic [3:0] cur_hour_low,
    input  logic [3:0] cur_min_high,
    input  logic [3:0] cur_min_low,
    input  logic       btn_hour_n,
    input  logic       btn_min_n,
    input  logic       btn_arm_n,
    input  logic       btn_snooze_n,
    output logic [1:0] alarm_hour_high,
    output logic [3:0] alarm_hour_low,
    output logic [3:0] alarm_min_high,
    output logic [3:0] alarm_min_low,
    output logic       alarm_armed,
    output logic       ringing,
    output logic       buzzer
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW  = $clog2(RING_SECONDS + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]  RING_LAST = RW'(RING_SECONDS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
`ifdef ALARM_SNOOZE_EN
    localparam logic [1:0] ST_SNOOZE = 2'd2;
    localparam int SW = $clog2(SNOOZE_SECONDS + 1);
    localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECONDS - 1);
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
`endif

    // Button index: 0 hour, 1 min, 2 arm, 3 snooze
    logic [3:0]     btn_raw;
    logic [3:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]     db_lvl_q, db_lvl_d, press_q, press_d;
    logic [DBW-1:0] db_cnt_q [4];
    logic [DBW-1:0] db_cnt_d [4];

    logic       tick_r1_q, tick_r1_d, tick_r2_q, tick_r2_d, tick_pulse;
    logic [1:0] ah_hi_q, ah_hi_d;
    logic [3:0] ah_lo_q, ah_lo_d, am_hi_q, am_hi_d, am_lo_q, am_lo_d;
    logic       armed_q, armed_d;
    logic [1:0] state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic       beep_q, beep_d;
    logic       match_q, match_d, match_prev_q, match_prev_d, trigger;
    logic       ringing_q, ringing_d, buzzer_q, buzzer_d;

    assign btn_raw = {btn_snooze_n, btn_arm_n, btn_min_n, btn_hour_n};

    // Synchroniser + debounce: level flips only after DEBOUNCE_CYCLES
    // consecutive samples that disagree with it; a flip to 0 is a press.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        for (int i = 0; i < 4; i++) begin
            db_lvl_d[i] = db_lvl_q[i];
            db_cnt_d[i] = '0;
            press_d[i]  = 1'b0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_d[i] = sync2_q[i];
                    press_d[i]  = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tick_r1_d  = sec_tick;
    assign tick_r2_d  = tick_r1_q;
    assign tick_pulse = tick_r1_q & ~tick_r2_q;

    // Edge on match (not level) so stopping inside the matching minute
    // does not immediately ring again.
    assign trigger = match_q & ~match_prev_q & armed_q;

    always_comb begin
        ah_hi_d      = ah_hi_q;
        ah_lo_d      = ah_lo_q;
        am_hi_d      = am_hi_q;
        am_lo_d      = am_lo_q;
        armed_d      = armed_q;
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        beep_d       = beep_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d    = snz_cnt_q;
`endif
        match_d      = ({cur_hour_high, cur_hour_low, cur_min_high, cur_min_low} ==
                        {ah_hi_q, ah_lo_q, am_hi_q, am_lo_q});
        match_prev_d = match_q;

        case (state_q)
            ST_IDLE: begin
                if (press_q[0]) begin
                    if (ah_hi_q == 2'd2 && ah_lo_q == 4'd3) begin
                        ah_hi_d = 2'd0;
                        ah_lo_d = 4'd0;
                    end else if (ah_lo_q == 4'd9) begin
                        ah_hi_d = ah_hi_q + 2'd1;
                        ah_lo_d = 4'd0;
                    end else begin
                        ah_lo_d = ah_lo_q + 4'd1;
                    end
                end
                if (press_q[1]) begin
                    if (am_lo_q == 4'd9) begin
                        am_lo_d = 4'd0;
                        am_hi_d = (am_hi_q == 4'd5) ? 4'd0 : am_hi_q + 4'd1;
                    end else begin
                        am_lo_d = am_lo_q + 4'd1;
                    end
                end
                if (press_q[2]) begin
                    armed_d = ~armed_q;
                end else if (trigger) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                    beep_d     = 1'b1;
                end
            end
            ST_RING: begin
                if (press_q[2]) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b0;
                end else if (press_q[3]) begin
`ifdef ALARM_SNOOZE_EN
                    state_d   = ST_SNOOZE;
                    snz_cnt_d = '0;
`else
                    state_d   = ST_IDLE;
`endif
                end else if (tick_pulse) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                        beep_d     = ~beep_q;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (press_q[2]) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b0;
                end else if (tick_pulse) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = ST_RING;
                        ring_cnt_d = '0;
                        beep_d     = 1'b1;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        ringing_d = (state_d == ST_RING);
        buzzer_d  = ringing_d & beep_d;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_q      <= 4'hF;
            sync2_q      <= 4'hF;
            db_lvl_q     <= 4'hF;
            press_q      <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            tick_r1_q    <= 1'b0;
            tick_r2_q    <= 1'b0;
            ah_hi_q      <= '0;
            ah_lo_q      <= '0;
            am_hi_q      <= '0;
            am_lo_q      <= '0;
            armed_q      <= 1'b0;
            state_q      <= ST_IDLE;
            ring_cnt_q   <= '0;
            beep_q       <= 1'b0;
            match_q      <= 1'b0;
            match_prev_q <= 1'b0;
            ringing_q    <= 1'b0;
            buzzer_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q    <= '0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_lvl_q     <= db_lvl_d;
            press_q      <= press_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            tick_r1_q    <= tick_r1_d;
            tick_r2_q    <= tick_r2_d;
            ah_hi_q      <= ah_hi_d;
            ah_lo_q      <= ah_lo_d;
            am_hi_q      <= am_hi_d;
            am_lo_q      <= am_lo_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            beep_q       <= beep_d;
            match_q      <= match_d;
            match_prev_q <= match_prev_d;
            ringing_q    <= ringing_d;
            buzzer_q     <= buzzer_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q    <= snz_cnt_d;
`endif
        end
    end

    assign alarm_hour_high = ah_hi_q;
    assign alarm_hour_low  = ah_lo_q;
    assign alarm_min_high  = am_hi_q;
    assign alarm_min_low   = am_lo_q;
    assign alarm_armed     = armed_q;
    assign ringing         = ringing_q;
    assign buzzer          = buzzer_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit with DEBOUNCE_CYCLES=4, RING_SECONDS=3, SNOOZE_SECONDS=5.
// Reference model keeps the alarm as plain hour/minute integers and the
// ringing expectation as a simple count of seconds.

module tb_alarm_unit;
    localparam int DB = 4, RS = 3, SS = 5;

    logic       clk_in = 1'b0;
    logic       reset, sec_tick;
    logic [1:0] cur_hour_high;
    logic [3:0] cur_hour_low, cur_min_high, cur_min_low;
    logic       btn_hour_n, btn_min_n, btn_arm_n, btn_snooze_n;
    logic [1:0] alarm_hour_high;
    logic [3:0] alarm_hour_low, alarm_min_high, alarm_min_low;
    logic       alarm_armed, ringing, buzzer;

    int n_checks = 0;
    int n_err    = 0;
    int m_hour, m_min;
    bit m_armed;

    alarm_unit #(.DEBOUNCE_CYCLES(DB), .RING_SECONDS(RS), .SNOOZE_SECONDS(SS)) dut (
        .clk_in(clk_in), .reset(reset), .sec_tick(sec_tick),
        .cur_hour_high(cur_hour_high), .cur_hour_low(cur_hour_low),
        .cur_min_high(cur_min_high), .cur_min_low(cur_min_low),
        .btn_hour_n(btn_hour_n), .btn_min_n(btn_min_n),
        .btn_arm_n(btn_arm_n), .btn_snooze_n(btn_snooze_n),
        .alarm_hour_high(alarm_hour_high), .alarm_hour_low(alarm_hour_low),
        .alarm_min_high(alarm_min_high), .alarm_min_low(alarm_min_low),
        .alarm_armed(alarm_armed), .ringing(ringing), .buzzer(buzzer)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic press(input bit h, input bit m, input bit a, input bit s);
        btn_hour_n = ~h; btn_min_n = ~m; btn_arm_n = ~a; btn_snooze_n = ~s;
        cyc(2 * DB);
        btn_hour_n = 1'b1; btn_min_n = 1'b1; btn_arm_n = 1'b1; btn_snooze_n = 1'b1;
        cyc(2 * DB);
    endtask

    task automatic sec_pulse();
        sec_tick = 1'b1; cyc(2);
        sec_tick = 1'b0; cyc(2);
    endtask

    task automatic set_cur(input int hh, input int mm);
        cur_hour_high = 2'(hh / 10); cur_hour_low = 4'(hh % 10);
        cur_min_high  = 4'(mm / 10); cur_min_low  = 4'(mm % 10);
    endtask

    task automatic check_alarm(input string tag);
        bit bcd_ok;
        bcd_ok = (alarm_hour_low <= 4'd9) && (alarm_min_high <= 4'd5) &&
                 (alarm_min_low <= 4'd9) && (alarm_hour_high <= 2'd2);
        check({tag, "_hr"},  int'(alarm_hour_high) * 10 + int'(alarm_hour_low), m_hour);
        check({tag, "_min"}, int'(alarm_min_high) * 10 + int'(alarm_min_low), m_min);
        check({tag, "_bcd"}, 32'(bcd_ok), 1);
    endtask

    task automatic goto_alarm(input int hh, input int mm);
        while (m_hour != hh) begin press(1, 0, 0, 0); m_hour = (m_hour + 1) % 24; end
        while (m_min != mm)  begin press(0, 1, 0, 0); m_min  = (m_min + 1) % 60; end
    endtask

    task automatic retrigger_0730();
        set_cur(7, 31); cyc(3);
        set_cur(7, 30); cyc(3);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sec_tick = 1'b0;
        btn_hour_n = 1'b1; btn_min_n = 1'b1; btn_arm_n = 1'b1; btn_snooze_n = 1'b1;
        set_cur(12, 0);
        cyc(3);
        reset = 1'b0;
        m_hour = 0; m_min = 0; m_armed = 0;
        cyc(1);
        check_alarm("rst");
        check("rst_armed", 32'(alarm_armed), 0);
        check("rst_ring",  32'(ringing), 0);
        check("rst_buzz",  32'(buzzer), 0);

        // Short glitch must be rejected
        btn_hour_n = 1'b0; cyc(2); btn_hour_n = 1'b1; cyc(20);
        check_alarm("glitch");

        for (int i = 0; i < 24; i++) begin
            press(1, 0, 0, 0); m_hour = (m_hour + 1) % 24; check_alarm("hseq");
        end
        for (int i = 0; i < 61; i++) begin
            press(0, 1, 0, 0); m_min = (m_min + 1) % 60; check_alarm("mseq");
        end
        press(1, 1, 0, 0);
        m_hour = (m_hour + 1) % 24; m_min = (m_min + 1) % 60;
        check_alarm("both");

        for (int k = 0; k < 4; k++) begin
            goto_alarm(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
            check_alarm("rnd");
        end

        // Ring at 07:30, auto-stop after RS ticks with beep toggling
        set_cur(7, 29);
        goto_alarm(7, 30);
        press(0, 0, 1, 0); m_armed = 1;
        check("arm_on", 32'(alarm_armed), 32'(m_armed));
        set_cur(7, 30); cyc(2);
        check("ring_start", 32'(ringing), 1);
        check("buzz_start", 32'(buzzer), 1);
        for (int t = 1; t <= RS; t++) begin
            sec_pulse();
            check("ring_tick", 32'(ringing), 32'(t < RS));
            check("buzz_tick", 32'(buzzer), 32'((t < RS) && (t % 2 == 0)));
        end
        check("ring_armed", 32'(alarm_armed), 1);

        // Edits ignored while ringing; arm+snooze together stops and disarms
        retrigger_0730();
        check("ring2", 32'(ringing), 1);
        press(1, 0, 0, 0);
        check_alarm("ringedit");
        check("ring2_hold", 32'(ringing), 1);
        press(0, 0, 1, 1); m_armed = 0;
        check("armsnz_ring",  32'(ringing), 0);
        check("armsnz_armed", 32'(alarm_armed), 0);
        cyc(20);
        check("noretrig", 32'(ringing), 0);

        // Snooze
        press(0, 0, 1, 0); m_armed = 1;
        check("arm_steady", 32'(ringing), 0);
        retrigger_0730();
        check("ring3", 32'(ringing), 1);
        press(0, 0, 0, 1);
        check("snz_ring",  32'(ringing), 0);
        check("snz_armed", 32'(alarm_armed), 1);
        for (int t = 1; t <= SS; t++) begin
            sec_pulse();
`ifdef ALARM_SNOOZE_EN
            check("snz_tick", 32'(ringing), 32'(t == SS));
`else
            check("snz_tick", 32'(ringing), 0);
`endif
        end
        press(0, 0, 1, 0); m_armed = 0;
        check("snz_stop", 32'(ringing), 0);
        check("snz_disarm", 32'(alarm_armed), 0);

        // Editing the alarm onto the current time while armed triggers
        press(0, 1, 0, 0); m_min = (m_min + 1) % 60;
        set_cur(7, 32);
        press(0, 0, 1, 0); m_armed = 1;
        check("edit_pre", 32'(ringing), 0);
        press(0, 1, 0, 0); m_min = (m_min + 1) % 60;
        check_alarm("edit");
        check("edit_ring", 32'(ringing), 1);

        // Reset mid-ringing
        reset = 1'b1; cyc(1); reset = 1'b0;
        m_hour = 0; m_min = 0; m_armed = 0;
        check("mrst_ring",  32'(ringing), 0);
        check("mrst_buzz",  32'(buzzer), 0);
        check("mrst_armed", 32'(alarm_armed), 0);
        check_alarm("mrst");

        // Random alarm times ring when the running time arrives
        for (int k = 0; k < 3; k++) begin
            int hh, mm;
            hh = int'($urandom_range(0, 23));
            mm = int'($urandom_range(0, 59));
            set_cur((hh + 12) % 24, mm);
            goto_alarm(hh, mm);
            press(0, 0, 1, 0); m_armed = 1;
            check("rr_quiet", 32'(ringing), 0);
            set_cur(hh, mm); cyc(3);
            check("rr_ring", 32'(ringing), 1);
            press(0, 0, 1, 0); m_armed = 0;
            check("rr_stop", 32'(ringing), 0);
            check("rr_armed", 32'(alarm_armed), 32'(m_armed));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
